// File: rtl/timer_pkg.sv
// Shared types and digit limits for the BCD countdown timer.
// Imported by the timer top level.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_e;

    localparam logic [3:0] MAX_MIN      = 4'd9;
    localparam logic [3:0] MAX_SEC_TENS = 4'd5;
    localparam logic [3:0] MAX_SEC_ONES = 4'd9;

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts enabled cycles and emits a tick
// on the cycle the count wraps from TICKS_PER_SEC-1 to zero.
module tick_gen #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(TICKS_PER_SEC);
    localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer.sv
// BCD countdown timer (0:00 to 9:59) with run/pause/done control,
// preset loading with range validation and registered status flags.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_min,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_sec_ones,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       load_err
);

    state_e     state_q, state_d;
    logic [3:0] min_q, min_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       running_q;
    logic       done_q, done_d;
    logic       load_err_q, load_err_d;

    logic tick;
    logic cnt_en;
    logic cnt_clr;
    logic load_ok;
    logic at_zero;
    logic at_one;

    assign load_ok = (load_min <= MAX_MIN)
                  && (load_sec_tens <= MAX_SEC_TENS)
                  && (load_sec_ones <= MAX_SEC_ONES);
    assign at_zero = (min_q == 4'd0) && (tens_q == 4'd0)
                  && (ones_q == 4'd0);
    assign at_one  = (min_q == 4'd0) && (tens_q == 4'd0)
                  && (ones_q == 4'd1);

    // A load seen in RUN still outranks stop, so counting carries on.
    assign cnt_en  = (state_q == RUN) && !clear && (load || !stop);
    assign cnt_clr = clear
                  || (load && (state_q != RUN) && load_ok)
                  || (!load && !stop && start
                      && (state_q == IDLE) && !at_zero);

    tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        min_d      = min_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        if (clear) begin
            state_d = IDLE;
            min_d   = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else if (load) begin
            if (state_q != RUN) begin
                if (load_ok) begin
                    state_d = IDLE;
                    min_d   = load_min;
                    tens_d  = load_sec_tens;
                    ones_d  = load_sec_ones;
                end else begin
                    load_err_d = 1'b1;
                end
            end
        end else if (stop) begin
            if (state_q == RUN) state_d = PAUSED;
        end else if (start) begin
            if ((state_q == IDLE && !at_zero) || state_q == PAUSED)
                state_d = RUN;
        end

        // tick only fires in RUN when no command has altered the digits
        if (tick) begin
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else begin
                ones_d = MAX_SEC_ONES;
                if (tens_q != 4'd0) begin
                    tens_d = tens_q - 4'd1;
                end else begin
                    tens_d = MAX_SEC_TENS;
                    min_d  = min_q - 4'd1;
                end
            end
            if (at_one) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            min_q      <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            running_q  <= (state_d == RUN);
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign min      = min_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign running  = running_q;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random commands,
// compared each cycle against a seconds-based reference model.
module tb_countdown_timer;

    localparam int TPS = 4;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_min = '0;
    logic [3:0] load_sec_tens = '0;
    logic [3:0] load_sec_ones = '0;
    logic [3:0] min, sec_tens, sec_ones;
    logic       running, done, load_err;

    int checks = 0;
    int errors = 0;

    int m_secs = 0;
    int m_phase = 0;
    int m_st = S_IDLE;
    bit m_done = 0;
    bit m_err = 0;

    always #5 clk = ~clk;

    countdown_timer #(
        .TICKS_PER_SEC(TPS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .clear        (clear),
        .load         (load),
        .load_min     (load_min),
        .load_sec_tens(load_sec_tens),
        .load_sec_ones(load_sec_ones),
        .min          (min),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .running      (running),
        .done         (done),
        .load_err     (load_err)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One counted cycle of a running timer: whole seconds, not digits.
    function automatic void m_count();
        if (m_phase == TPS - 1) begin
            m_phase = 0;
            m_secs--;
            if (m_secs == 0) begin
                m_st   = S_DONE;
                m_done = 1;
            end
        end else begin
            m_phase++;
        end
    endfunction

    function automatic void m_step();
        m_done = 0;
        m_err  = 0;
        if (reset) begin
            m_secs = 0; m_phase = 0; m_st = S_IDLE;
        end else if (clear) begin
            m_secs = 0; m_phase = 0; m_st = S_IDLE;
        end else if (load) begin
            if (m_st == S_RUN) begin
                m_count();
            end else if (load_min <= 9 && load_sec_tens <= 5
                         && load_sec_ones <= 9) begin
                m_secs = int'(load_min) * 60 + int'(load_sec_tens) * 10
                       + int'(load_sec_ones);
                m_phase = 0;
                m_st = S_IDLE;
            end else begin
                m_err = 1;
            end
        end else if (stop) begin
            if (m_st == S_RUN) m_st = S_PAUSE;
        end else if (start) begin
            if (m_st == S_IDLE && m_secs > 0) begin
                m_st = S_RUN; m_phase = 0;
            end else if (m_st == S_PAUSE) begin
                m_st = S_RUN;
            end else if (m_st == S_RUN) begin
                m_count();
            end
        end else if (m_st == S_RUN) begin
            m_count();
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        m_step();
        #1;
        check("min", min, m_secs / 60);
        check("tens", sec_tens, (m_secs % 60) / 10);
        check("ones", sec_ones, m_secs % 10);
        check("running", running, m_st == S_RUN);
        check("done", done, m_done);
        check("load_err", load_err, m_err);
    endtask

    task automatic cmd(bit r, bit c, bit l, bit sp, bit st);
        reset = r; clear = c; load = l; stop = sp; start = st;
        cycle();
        reset = 0; clear = 0; load = 0; stop = 0; start = 0;
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    task automatic preset(int m, int t, int o);
        load_min = 4'(m);
        load_sec_tens = 4'(t);
        load_sec_ones = 4'(o);
    endtask

    initial begin
        cmd(1, 0, 0, 0, 0);
        cmd(1, 0, 0, 0, 0);
        check("rst_digits", {min, sec_tens, sec_ones}, 12'h000);
        check("rst_flags", {running, done, load_err}, 3'b000);

        preset(0, 0, 3);
        cmd(0, 0, 1, 0, 0);
        cmd(0, 0, 0, 0, 1);
        run(4);
        check("cd_002", {min, sec_tens, sec_ones}, 12'h002);
        run(8);
        check("cd_done", done, 1);
        check("cd_zero", {min, sec_tens, sec_ones}, 12'h000);
        run(1);
        check("cd_done_once", done, 0);
        check("cd_not_running", running, 0);

        preset(1, 0, 0);
        cmd(0, 0, 1, 0, 0);
        cmd(0, 0, 0, 0, 1);
        run(4);
        check("borrow_059", {min, sec_tens, sec_ones}, 12'h059);
        run(4);
        check("borrow_058", {min, sec_tens, sec_ones}, 12'h058);

        run(2);
        cmd(0, 0, 0, 1, 0);
        run(10);
        check("pause_frozen", {min, sec_tens, sec_ones}, 12'h058);
        check("pause_run", running, 0);
        cmd(0, 0, 0, 0, 1);
        run(1);
        check("resume_hold", {min, sec_tens, sec_ones}, 12'h058);
        run(1);
        check("resume_dec", {min, sec_tens, sec_ones}, 12'h057);

        preset(2, 2, 2);
        cmd(0, 0, 1, 0, 0);
        check("run_load_err", load_err, 0);
        check("run_load_ign", {min, sec_tens, sec_ones}, 12'h057);
        cmd(0, 0, 0, 1, 0);
        preset(3, 7, 2);
        cmd(0, 0, 1, 0, 0);
        check("bad_load_err", load_err, 1);
        check("bad_load_keep", {min, sec_tens, sec_ones}, 12'h057);
        run(1);
        check("bad_load_pulse", load_err, 0);

        cmd(0, 0, 0, 0, 1);
        preset(0, 0, 3);
        cmd(0, 1, 1, 0, 1);
        check("prio_clear", {min, sec_tens, sec_ones, running}, 13'h0);

        cmd(0, 0, 1, 0, 0);
        cmd(0, 0, 0, 0, 1);
        run(3);
        cmd(0, 0, 0, 1, 0);
        check("stop_wrap", {min, sec_tens, sec_ones}, 12'h003);
        cmd(0, 0, 0, 0, 1);
        check("stop_wrap_rs", {min, sec_tens, sec_ones}, 12'h003);
        run(1);
        check("resume_first", {min, sec_tens, sec_ones}, 12'h002);

        preset(0, 0, 1);
        cmd(0, 0, 1, 0, 0);
        cmd(0, 0, 0, 0, 1);
        run(2);
        cmd(1, 0, 0, 0, 0);
        check("midrst_digits", {min, sec_tens, sec_ones}, 12'h000);
        check("midrst_flags", {running, done, load_err}, 3'b000);
        run(4);
        check("midrst_nodone", done, 0);
        cmd(0, 0, 0, 0, 1);
        check("zero_start", running, 0);

        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            clear = ($urandom_range(0, 79) == 0);
            load  = ($urandom_range(0, 24) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0)
                preset($urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 15));
            else
                preset($urandom_range(0, 1), $urandom_range(0, 5),
                       $urandom_range(0, 9));
            cycle();
        end
        reset = 0; clear = 0; load = 0; stop = 0; start = 0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

BCD countdown timer with a run/pause/done state machine and an internal one-second prescaler. It produces the three digit values (minutes, tens of seconds, units of seconds) that the seven-segment decoder stage consumes directly. It also produces status flags for the surrounding control logic. The range is 0:00 to 9:59.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per counted second; must be ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level sampled each cycle; begins or resumes counting.
- `stop`  in  1  pauses counting.
- `clear`  in  1  returns to 0:00, IDLE.
- `load`  in  1  loads preset digits.
- `load_min`  in  4  preset minutes, valid range 0–9.
- `load_sec_tens`  in  4  preset tens of seconds, valid range 0–5.
- `load_sec_ones`  in  4  preset units of seconds, valid range 0–9.
- `min`  out  4  current minutes, BCD.
- `sec_tens`  out  4  current tens of seconds, BCD.
- `sec_ones`  out  4  current units of seconds, BCD.
- `running`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the count reaches 0:00.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- States:
  - IDLE: reset state, digits static.
  - RUN: counting.
  - PAUSED: halted mid-count, prescaler value retained.
  - DONE: expired, digits held at 0:00.
- Command priority, high to low: `reset` > `clear` > `load` > `stop` > `start`. Only the highest-priority asserted command acts in a given cycle.
- `clear` (any state): digits ← 0:00, prescaler ← 0, state ← IDLE.
- `load` in IDLE, PAUSED or DONE:
  - If all digits are in range: digits ← preset, prescaler ← 0, state ← IDLE.
  - If any digit is out of range: digits unchanged, state unchanged, `load_err` pulses.
  - In RUN, `load` is ignored and produces no `load_err`.
- `stop` in RUN: state ← PAUSED. In any other state it is ignored.
- `start` transitions:
  - IDLE with a nonzero count: state ← RUN, prescaler ← 0.
  - IDLE at 0:00: ignored.
  - PAUSED: state ← RUN, prescaler kept.
  - RUN or DONE: ignored.
- Prescaler behaviour in RUN:
  - Increments every cycle.
  - At `TICKS_PER_SEC`−1 it wraps to 0 and issues a decrement.
- Decrement rule:
  - If `sec_ones` > 0: `sec_ones` − 1.
  - Otherwise, `sec_ones` ← 9, and:
    - if `sec_tens` > 0: `sec_tens` − 1;
    - otherwise `sec_tens` ← 5 and `min` − 1.
- Decrement from 0:01 to 0:00: state ← DONE and `done` pulses.
- Digits never leave their ranges and never wrap below 0:00.

## Timing
- All outputs are registered.
- Reset values:
  - `min`, `sec_tens`, `sec_ones` = 0.
  - `running`, `done`, `load_err` = 0.
  - State = IDLE; prescaler = 0.
- Command latency: a command sampled at edge N is visible on the outputs from edge N onward, i.e. one cycle after it was presented.
- First decrement after `start` from IDLE: exactly `TICKS_PER_SEC` cycles after the start edge. Subsequent decrements occur every `TICKS_PER_SEC` cycles.
- `done` is high for exactly one cycle: the same cycle in which the digits first read 0:00 and `running` falls.
- `stop` and the prescaler wrap in the same cycle: `stop` wins. No decrement occurs, and the prescaler holds `TICKS_PER_SEC`−1, so resuming decrements on the first RUN cycle.
- `start` held continuously: acts once per applicable state; it does not restart a running count.
- `reset` mid-count: all state returns to reset values on the next edge, and no `done` pulse is produced.

## Structure
- Package `timer_pkg` contains:
  - state enum (IDLE, RUN, PAUSED, DONE);
  - constants MAX_MIN = 9, MAX_SEC_TENS = 5, MAX_SEC_ONES = 9.
- Sub-module `tick_gen`:
  - Parameterised prescaler with `clk`, `reset`, `en`, `clr` inputs and a one-cycle `tick` output.
  - Counter width is $clog2(`TICKS_PER_SEC`).
- The top level holds the FSM, the BCD decrement logic and the load validation.

## Test plan
All scenarios use `TICKS_PER_SEC` = 4.
- Basic countdown: reset, load 0:03, start → digits 0:02, 0:01, 0:00 at +4, +8 and +12 cycles; `done` pulses once at +12; `running` low afterwards.
- Borrow chain: load 1:00, start → after 4 cycles the digits read 0:59; after a further 4 cycles, 0:58.
- Pause and resume: in RUN, stop after 2 prescaler cycles, hold 10 cycles, then start → next decrement 2 cycles after resume; digits frozen during the pause.
- Invalid load: load 3:7:2 (tens = 7) → `load_err` pulses for 1 cycle and the digits are unchanged. Load issued during RUN → ignored, no `load_err`.
- Priority: `clear`+`load`+`start` asserted together in RUN → 0:00, IDLE. `stop` coinciding with the prescaler wrap → no decrement.
- Reset mid-count: at 0:01, with the prescaler at 2, assert `reset` → all outputs 0 next cycle and no `done` pulse; `start` at 0:00 is then ignored.
